// File: rtl/fir_symmetry_mc_sequencer_pkg.sv
// Shared FSM encoding and default sizing for the multi-cycle symmetric FIR sequencer and its sections.
package fir_mc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_DW  = 16;
  localparam int DEF_N   = 8;
  localparam int DEF_LGN = 3;

endpackage

// File: rtl/fir_symmetry_mc_sequencer_if.sv
// Sample handshake, slot/coefficient outputs and coefficient write port of the FIR sequencer.
interface fir_symmetry_mc_sequencer_if
  import fir_mc_pkg::*;
#(
  parameter int DW  = DEF_DW,
  parameter int LGN = DEF_LGN
);

  // A sample transfers on a rising edge where sample_valid && sample_ready; upstream holds
  // sample_valid (no retraction) until that edge, and sample_ready never depends on sample_valid.
  logic                  sample_valid;
  logic                  sample_ready;
  logic                  ce;
  logic [LGN-1:0]        cycle;
  logic signed [DW-1:0]  coeff;
  logic                  out_valid;
  logic                  cw_en;
  logic [LGN-1:0]        cw_addr;
  logic signed [DW-1:0]  cw_data;
  logic                  cw_commit;
  logic                  commit_pend;

  modport master (
    output sample_valid, cw_en, cw_addr, cw_data, cw_commit,
    input  sample_ready, ce, cycle, coeff, out_valid, commit_pend
  );

  modport slave (
    input  sample_valid, cw_en, cw_addr, cw_data, cw_commit,
    output sample_ready, ce, cycle, coeff, out_valid, commit_pend
  );

endinterface

// File: rtl/fir_symmetry_mc_sequencer_coeff_bank.sv
// Coefficient store: write port, optional shadow->live commit (FIR_MC_SHADOW_BANK_EN) and read mux.
module fir_mc_coeff_bank #(
  parameter int DW  = 16,
  parameter int N   = 8,
  parameter int LGN = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en_i,
  input  logic [LGN-1:0]       wr_addr_i,
  input  logic signed [DW-1:0] wr_data_i,
  input  logic                 commit_i,
  input  logic [LGN-1:0]       rd_idx_i,
  output logic signed [DW-1:0] rd_data_o
);

  logic                 wr_hit;
  logic signed [DW-1:0] live_q [N];
  logic signed [DW-1:0] live_d [N];

  assign wr_hit = wr_en_i && (int'(wr_addr_i) < N);

`ifdef FIR_MC_SHADOW_BANK_EN
  logic signed [DW-1:0] shadow_q [N];
  logic signed [DW-1:0] shadow_d [N];

  // A write landing on the commit edge is folded into the copy.
  always_comb begin
    shadow_d = shadow_q;
    if (wr_hit) shadow_d[wr_addr_i] = wr_data_i;
    if (commit_i) live_d = shadow_d;
    else          live_d = live_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        live_q[i]   <= '0;
        shadow_q[i] <= '0;
      end
    end else begin
      live_q   <= live_d;
      shadow_q <= shadow_d;
    end
  end
`else
  logic unused_commit;
  assign unused_commit = commit_i;

  always_comb begin
    live_d = live_q;
    if (wr_hit) live_d[wr_addr_i] = wr_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) live_q[i] <= '0;
    end else begin
      live_q <= live_d;
    end
  end
`endif

  // Read from the next-state bank so the registered coeff sees this edge's write/commit.
  assign rd_data_o = (int'(rd_idx_i) < N) ? live_d[rd_idx_i] : '0;

endmodule

// File: rtl/fir_symmetry_mc_sequencer.sv
// Sequencer for time-multiplexed symmetric FIR sections: N slots per sample with registered cycle/coeff.
// Define FIR_MC_SHADOW_BANK_EN for a double-buffered coefficient store with deferred commit.
module fir_symmetry_mc_sequencer
  import fir_mc_pkg::*;
#(
  parameter int DW  = DEF_DW,
  parameter int N   = DEF_N,
  parameter int LGN = DEF_LGN
) (
  input  logic                      clk_sample,
  input  logic                      reset_n,
  fir_symmetry_mc_sequencer_if.slave bus,
  output state_t                    dbg_state_o
);

  localparam logic [LGN-1:0] LAST = LGN'(N - 1);

  state_t               state_q, state_d;
  logic [LGN-1:0]       cycle_q, cycle_d;
  logic                 ce_q;
  logic                 out_valid_q;
  logic signed [DW-1:0] coeff_q, coeff_d;
  logic                 commit_pend_q, commit_pend_d;
  logic                 commit_apply;

  always_comb begin
    state_d = state_q;
    cycle_d = '0;
    unique case (state_q)
      IDLE: if (bus.sample_valid) state_d = RUN;
      RUN: begin
        if (cycle_q == LAST) state_d = DONE;
        else                 cycle_d = cycle_q + 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef FIR_MC_SHADOW_BANK_EN
  // The live bank only changes between samples, so a pending commit waits for IDLE.
  assign commit_apply  = commit_pend_q && (state_q == IDLE);
  assign commit_pend_d = bus.cw_commit || (commit_pend_q && !commit_apply);
`else
  logic unused_cw_commit;
  assign unused_cw_commit = bus.cw_commit;
  assign commit_apply     = 1'b0;
  assign commit_pend_d    = 1'b0;
`endif

  fir_mc_coeff_bank #(
    .DW (DW),
    .N  (N),
    .LGN(LGN)
  ) u_bank (
    .clk      (clk_sample),
    .rst_n    (reset_n),
    .wr_en_i  (bus.cw_en),
    .wr_addr_i(bus.cw_addr),
    .wr_data_i(bus.cw_data),
    .commit_i (commit_apply),
    .rd_idx_i (cycle_d),
    .rd_data_o(coeff_d)
  );

  always_ff @(posedge clk_sample or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      cycle_q       <= '0;
      ce_q          <= 1'b0;
      out_valid_q   <= 1'b0;
      coeff_q       <= '0;
      commit_pend_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cycle_q       <= cycle_d;
      ce_q          <= (state_d == RUN);
      out_valid_q   <= (state_d == DONE);
      coeff_q       <= coeff_d;
      commit_pend_q <= commit_pend_d;
    end
  end

  assign bus.sample_ready = (state_q == IDLE);
  assign bus.ce           = ce_q;
  assign bus.cycle        = cycle_q;
  assign bus.coeff        = coeff_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.commit_pend  = commit_pend_q;
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_fir_symmetry_mc_sequencer.sv
// Bench for fir_symmetry_mc_sequencer: sample-level model checked every cycle plus directed literal checks.
module tb_fir_symmetry_mc_sequencer;
  import fir_mc_pkg::*;

  localparam int DW = 16;
  localparam int N  = 8;
  localparam int LGN = 3;
  localparam int N2 = 6;

`ifdef FIR_MC_SHADOW_BANK_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  fir_symmetry_mc_sequencer_if #(.DW(DW), .LGN(LGN)) bus ();
  fir_symmetry_mc_sequencer_if #(.DW(DW), .LGN(LGN)) bus2 ();
  state_t dbg_state, dbg_state2;

  fir_symmetry_mc_sequencer #(.DW(DW), .N(N), .LGN(LGN)) dut (
    .clk_sample (clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .dbg_state_o(dbg_state)
  );

  fir_symmetry_mc_sequencer #(.DW(DW), .N(N2), .LGN(LGN)) dut2 (
    .clk_sample (clk),
    .reset_n    (reset_n),
    .bus        (bus2),
    .dbg_state_o(dbg_state2)
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- sample-level model ----------------
  // m_slot: -1 waiting for a sample, 0..N-1 compute slot, N result slot.
  int              m_slot;
  logic [DW-1:0]   m_live [N];
  logic [DW-1:0]   m_shadow [N];
  bit              m_pend;
  bit              chk_on = 0;

  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      m_slot = -1;
      m_pend = 0;
      for (int i = 0; i < N; i++) begin
        m_live[i] = '0;
        m_shadow[i] = '0;
      end
    end else begin : model_step
      bit idle;
      idle = (m_slot < 0);
      if (SHADOW) begin
        if (bus.cw_en && int'(bus.cw_addr) < N) m_shadow[bus.cw_addr] = bus.cw_data;
        if (m_pend && idle) begin
          m_live = m_shadow;
          m_pend = 0;
        end
        if (bus.cw_commit) m_pend = 1;
      end else begin
        if (bus.cw_en && int'(bus.cw_addr) < N) m_live[bus.cw_addr] = bus.cw_data;
      end
      if (idle) begin
        if (bus.sample_valid) m_slot = 0;
      end else if (m_slot == N) m_slot = -1;
      else m_slot++;
    end
  end

  // ---------------- compare process and log ----------------
  bit             log_on = 0;
  bit             lg_ce[$], lg_ov[$], lg_rdy[$], lg_pend[$];
  logic [LGN-1:0] lg_cycle[$];
  logic [DW-1:0]  lg_coeff[$];

  initial forever begin : compare
    int c;
    logic [1:0] es;
    @(negedge clk);
    if (chk_on) begin
      c  = (m_slot >= 0 && m_slot < N) ? m_slot : 0;
      es = (m_slot < 0) ? 2'd0 : (m_slot < N) ? 2'd1 : 2'd2;
      chk("ready", {31'b0, bus.sample_ready}, {31'b0, m_slot < 0});
      chk("ce", {31'b0, bus.ce}, {31'b0, m_slot >= 0 && m_slot < N});
      chk("cycle", {29'b0, bus.cycle}, c);
      chk("coeff", {16'b0, bus.coeff}, {16'b0, m_live[c]});
      chk("out_valid", {31'b0, bus.out_valid}, {31'b0, m_slot == N});
      chk("commit_pend", {31'b0, bus.commit_pend}, {31'b0, m_pend});
      chk("state", {30'b0, dbg_state}, {30'b0, es});
    end
    if (log_on) begin
      lg_ce.push_back(bus.ce);
      lg_ov.push_back(bus.out_valid);
      lg_rdy.push_back(bus.sample_ready);
      lg_pend.push_back(bus.commit_pend);
      lg_cycle.push_back(bus.cycle);
      lg_coeff.push_back(bus.coeff);
    end
  end

  function automatic void clear_log();
    lg_ce.delete(); lg_ov.delete(); lg_rdy.delete();
    lg_pend.delete(); lg_cycle.delete(); lg_coeff.delete();
  endfunction

  function automatic int cnt(input bit q[$], input bit v);
    int n = 0;
    foreach (q[i]) if (q[i] == v) n++;
    return n;
  endfunction

  function automatic int find_cyc(input int k);
    for (int i = 0; i < lg_ce.size(); i++)
      if (lg_ce[i] && int'(lg_cycle[i]) == k) return i;
    return -1;
  endfunction

  function automatic logic [DW-1:0] coeff_at(input int k);
    int i = find_cyc(k);
    if (i < 0) return 16'hBAD0;
    return lg_coeff[i];
  endfunction

  function automatic int first_ov();
    foreach (lg_ov[i]) if (lg_ov[i]) return i;
    return -1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic write_coef(input int a, input logic [DW-1:0] d);
    bus.cw_en = 1'b1;
    bus.cw_addr = a[LGN-1:0];
    bus.cw_data = d;
    tick();
    bus.cw_en = 1'b0;
  endtask

  task automatic write_coef2(input int a, input logic [DW-1:0] d);
    bus2.cw_en = 1'b1;
    bus2.cw_addr = a[LGN-1:0];
    bus2.cw_data = d;
    tick();
    bus2.cw_en = 1'b0;
  endtask

  task automatic commit_pulse();
    bus.cw_commit = 1'b1;
    tick();
    bus.cw_commit = 1'b0;
  endtask

  // Returns at posedge+2 of the first compute slot.
  task automatic send_sample();
    bit ok = 0;
    bus.sample_valid = 1'b1;
    for (int g = 0; g < 40 && !ok; g++) begin
      @(negedge clk);
      ok = bus.sample_ready;
      tick();
    end
    bus.sample_valid = 1'b0;
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  // ---------------- directed stimulus ----------------
  int  i7, i_ov, errs, k, prev;
  int  ovs[$];
  bit  hit;
  logic [DW-1:0] exp6 [N2];
  logic [DW-1:0] got6 [N2];
  int  ce2;
  bit  ov2;

  initial begin
    bus.sample_valid = 0; bus.cw_en = 0; bus.cw_addr = '0; bus.cw_data = '0; bus.cw_commit = 0;
    bus2.sample_valid = 0; bus2.cw_en = 0; bus2.cw_addr = '0; bus2.cw_data = '0; bus2.cw_commit = 0;
    repeat (2) tick();
    chk_on = 1;
    @(negedge clk);
    chk("rst_ready", {31'b0, bus.sample_ready}, 32'd1);
    chk("rst_ce", {31'b0, bus.ce}, 32'd0);
    chk("rst_coeff", {16'b0, bus.coeff}, 32'd0);
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    tick();
    reset_n = 1'b1;
    repeat (2) tick();

    // 1: one sample with cleared banks
    clear_log(); log_on = 1;
    send_sample();
    repeat (10) tick();
    log_on = 0;
    chk("t1_ce_cycles", cnt(lg_ce, 1), 32'd8);
    chk("t1_ov_pulses", cnt(lg_ov, 1), 32'd1);
    chk("t1_busy_cycles", cnt(lg_rdy, 0), 32'd9);
    i7 = find_cyc(7);
    chk("t1_ov_after_7", {31'b0, (i7 >= 0) ? lg_ov[i7 + 1] : 1'b0}, 32'd1);
    errs = 0; k = 0;
    foreach (lg_ce[i]) if (lg_ce[i]) begin
      if (int'(lg_cycle[i]) != k || lg_coeff[i] != 0) errs++;
      k++;
    end
    chk("t1_cycle_seq", errs, 32'd0);

    // 2: load 1..8, commit while idle
    for (int a = 0; a < N; a++) write_coef(a, 16'(a + 1));
    clear_log(); log_on = 1;
    commit_pulse();
    repeat (3) tick();
    log_on = 0;
    chk("t2_pend_cycles", cnt(lg_pend, 1), SHADOW ? 32'd1 : 32'd0);
    clear_log(); log_on = 1;
    send_sample();
    repeat (10) tick();
    log_on = 0;
    for (int a = 0; a < N; a++) chk("t2_coeff_seq", {16'b0, coeff_at(a)}, 32'(a + 1));

    // 3: write+commit mid-sample
    clear_log(); log_on = 1;
    send_sample();
    bus.cw_en = 1; bus.cw_addr = 3'd3; bus.cw_data = 16'h7FFF; bus.cw_commit = 1;
    tick();
    bus.cw_en = 0; bus.cw_commit = 0;
    repeat (9) tick();
    log_on = 0;
    chk("t3_cur_coeff3", {16'b0, coeff_at(3)}, SHADOW ? 32'h4 : 32'h7FFF);
    i_ov = first_ov();
    chk("t3_pend_at_done", {31'b0, (i_ov >= 0) ? lg_pend[i_ov] : 1'b0}, {31'b0, SHADOW});
    clear_log(); log_on = 1;
    send_sample();
    repeat (10) tick();
    log_on = 0;
    chk("t3_next_coeff3", {16'b0, coeff_at(3)}, 32'h7FFF);
    chk("t3_next_coeff2", {16'b0, coeff_at(2)}, 32'h3);
    i_ov = first_ov();
    chk("t3_pend_cleared", {31'b0, (i_ov >= 0) ? lg_pend[i_ov] : 1'b1}, 32'd0);

    // 4: sample_valid held high
    clear_log(); log_on = 1;
    bus.sample_valid = 1;
    repeat (35) tick();
    bus.sample_valid = 0;
    repeat (12) tick();
    log_on = 0;
    ovs.delete();
    foreach (lg_ov[i]) if (lg_ov[i]) ovs.push_back(i);
    chk("t4_ov_count", ovs.size(), 32'd4);
    prev = -1;
    foreach (ovs[i]) begin
      if (prev >= 0) chk("t4_ov_period", ovs[i] - prev, 32'd10);
      prev = ovs[i];
    end

    // 5: reset mid-sample
    send_sample();
    hit = 0;
    for (int g = 0; g < 20; g++) begin
      @(negedge clk);
      if (bus.ce && bus.cycle == 3'd3) begin
        hit = 1;
        break;
      end
    end
    chk("t5_reach_cycle3", {31'b0, hit}, 32'd1);
    tick();
    reset_n = 1'b0;
    @(negedge clk);
    chk("t5_ready", {31'b0, bus.sample_ready}, 32'd1);
    chk("t5_ce", {31'b0, bus.ce}, 32'd0);
    chk("t5_cycle", {29'b0, bus.cycle}, 32'd0);
    chk("t5_coeff", {16'b0, bus.coeff}, 32'd0);
    chk("t5_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("t5_pend", {31'b0, bus.commit_pend}, 32'd0);
    tick();
    reset_n = 1'b1;
    clear_log(); log_on = 1;
    repeat (5) tick();
    log_on = 0;
    chk("t5_no_ov", cnt(lg_ov, 1), 32'd0);
    clear_log(); log_on = 1;
    send_sample();
    repeat (10) tick();
    log_on = 0;
    chk("t5_restart_cycle0", find_cyc(0) >= 0 ? 32'd1 : 32'd0, 32'd1);
    chk("t5_bank_cleared", {16'b0, coeff_at(3)}, 32'd0);

    // 7: write live[2] while at cycle 1
    clear_log(); log_on = 1;
    send_sample();
    tick();
    bus.cw_en = 1; bus.cw_addr = 3'd2; bus.cw_data = 16'd5;
    tick();
    bus.cw_en = 0;
    repeat (9) tick();
    log_on = 0;
    chk("t7_coeff_cycle2", {16'b0, coeff_at(2)}, SHADOW ? 32'd0 : 32'd5);
    chk("t7_coeff_cycle1", {16'b0, coeff_at(1)}, 32'd0);

    // 6: N=6 instance, out-of-range writes ignored
    write_coef2(6, 16'h1111);
    write_coef2(7, 16'h2222);
    write_coef2(5, 16'h0055);
    write_coef2(0, 16'h000A);
    bus2.cw_commit = 1;
    tick();
    bus2.cw_commit = 0;
    repeat (3) tick();
    bus2.sample_valid = 1;
    tick();
    bus2.sample_valid = 0;
    exp6[0] = 16'h000A; exp6[1] = 16'h0; exp6[2] = 16'h0;
    exp6[3] = 16'h0;    exp6[4] = 16'h0; exp6[5] = 16'h0055;
    ce2 = 0; ov2 = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i < N2) got6[i] = bus2.coeff;
      if (bus2.ce) ce2++;
      if (i == N2 && bus2.out_valid) ov2 = 1;
      tick();
    end
    for (int i = 0; i < N2; i++) chk("t6_coeff", {16'b0, got6[i]}, {16'b0, exp6[i]});
    chk("t6_ce_cycles", ce2, 32'd6);
    chk("t6_ov", {31'b0, ov2}, 32'd1);

    chk_on = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
